if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 150 +++++++++++++++
 tb/tb_if_stage.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, imem request FSM and the IF/ID pipeline register.
// Latency: one cycle from imem_ack_i to the IF/ID outputs, or one cycle from release of a stall in HOLD.
// Backpressure: pc_write_i/if_id_write_i stall the stage, and an ack taken during a stall is parked in a hold buffer.
//
// Ports:
//   clk_i, rst_i                 clock and synchronous active-high reset
//   start_i                      leave IDLE and begin fetching
//   pc_write_i, if_id_write_i    hazard-unit enables (0 = stall / hold)
//   flush_i, branch_target_i     redirect from ID; squashes IF/ID and any in-flight word
//   imem_req_o, imem_addr_o      instruction memory request and address (addr == pc_o)
//   imem_ack_i, imem_data_i      single-cycle ack with the fetched word
//   pc_o                         current fetch PC
//   if_id_*_o                    IF/ID register contents plus rs/rt fields for the hazard unit
//   fetch_stall_o                waiting on memory in FETCH
module if_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        pc_write_i,
  input  logic        if_id_write_i,
  input  logic        flush_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] if_id_pc4_o,
  output logic [31:0] if_id_inst_o,
  output logic        if_id_valid_o,
  output logic [4:0]  if_idrs_o,
  output logic [4:0]  if_idrt_o,
  output logic        fetch_stall_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_id_inst_q, if_id_inst_d;
  logic [31:0] if_id_pc4_q, if_id_pc4_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] hold_buf_q, hold_buf_d;
  logic        imem_req_q, imem_req_d;

  logic        advance;
  logic [31:0] pc_plus4;

  assign advance  = pc_write_i & if_id_write_i;
  assign pc_plus4 = pc_q + 32'd4;  // natural 32-bit wrap

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_id_inst_d  = if_id_inst_q;
    if_id_pc4_d   = if_id_pc4_q;
    if_id_valid_d = if_id_valid_q;
    hold_buf_d    = hold_buf_q;

    case (state_q)
      S_IDLE: begin
        // flush and stray acks are meaningless here; only start matters
        if (start_i) state_d = S_FETCH;
      end

      S_FETCH: begin
        if (flush_i) begin
          // redirect wins over a coincident ack: that word is wrong-path
          pc_d          = {branch_target_i[31:2], 2'b00};
          if_id_inst_d  = 32'd0;
          if_id_pc4_d   = 32'd0;
          if_id_valid_d = 1'b0;
          hold_buf_d    = 32'd0;
        end else if (imem_ack_i) begin
          if (advance) begin
            if_id_inst_d  = imem_data_i;
            if_id_pc4_d   = pc_plus4;
            if_id_valid_d = 1'b1;
            pc_d          = pc_plus4;
          end else begin
            // word arrived during a stall; park it so it is not refetched
            hold_buf_d = imem_data_i;
            state_d    = S_HOLD;
          end
        end else if (if_id_write_i) begin
          if_id_inst_d  = 32'd0;
          if_id_pc4_d   = 32'd0;
          if_id_valid_d = 1'b0;
        end
      end

      S_HOLD: begin
        if (flush_i) begin
          pc_d          = {branch_target_i[31:2], 2'b00};
          if_id_inst_d  = 32'd0;
          if_id_pc4_d   = 32'd0;
          if_id_valid_d = 1'b0;
          hold_buf_d    = 32'd0;
          state_d       = S_FETCH;
        end else if (advance) begin
          if_id_inst_d  = hold_buf_q;
          if_id_pc4_d   = pc_plus4;
          if_id_valid_d = 1'b1;
          pc_d          = pc_plus4;
          state_d       = S_FETCH;
        end
      end

      default: state_d = S_IDLE;
    endcase

    imem_req_d = (state_d == S_FETCH);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      pc_q          <= 32'd0;
      if_id_inst_q  <= 32'd0;
      if_id_pc4_q   <= 32'd0;
      if_id_valid_q <= 1'b0;
      hold_buf_q    <= 32'd0;
      imem_req_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_inst_q  <= if_id_inst_d;
      if_id_pc4_q   <= if_id_pc4_d;
      if_id_valid_q <= if_id_valid_d;
      hold_buf_q    <= hold_buf_d;
      imem_req_q    <= imem_req_d;
    end
  end

  assign imem_req_o    = imem_req_q;
  assign pc_o          = pc_q;
  assign imem_addr_o   = pc_q;
  assign if_id_inst_o  = if_id_inst_q;
  assign if_id_pc4_o   = if_id_pc4_q;
  assign if_id_valid_o = if_id_valid_q;
  assign if_idrs_o     = if_id_inst_q[25:21];
  assign if_idrt_o     = if_id_inst_q[20:16];
  // stall is about the current cycle's ack, so it is combinational on the input
  assign fetch_stall_o = (state_q == S_FETCH) && !imem_ack_i;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        pc_write_i = 1'b1;
  logic        if_id_write_i = 1'b1;
  logic        flush_i = 1'b0;
  logic [31:0] branch_target_i = 32'd0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_data_i = 32'd0;
  logic [31:0] pc_o;
  logic [31:0] if_id_pc4_o;
  logic [31:0] if_id_inst_o;
  logic        if_id_valid_o;
  logic [4:0]  if_idrs_o;
  logic [4:0]  if_idrt_o;
  logic        fetch_stall_o;

  if_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .pc_write_i(pc_write_i), .if_id_write_i(if_id_write_i),
    .flush_i(flush_i), .branch_target_i(branch_target_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
    .pc_o(pc_o), .if_id_pc4_o(if_id_pc4_o), .if_id_inst_o(if_id_inst_o),
    .if_id_valid_o(if_id_valid_o), .if_idrs_o(if_idrs_o), .if_idrt_o(if_idrt_o),
    .fetch_stall_o(fetch_stall_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: mode 0 = idle, 1 = fetching, 2 = holding a parked word.
  int          m_mode = 0;
  logic [31:0] m_pc = 0, m_inst = 0, m_pc4 = 0, m_buf = 0;
  logic        m_valid = 0;
  bit          m_known = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("imem_req",  {31'd0, imem_req_o},    {31'd0, m_mode == 1});
    chk("imem_addr", imem_addr_o,            m_pc);
    chk("pc",        pc_o,                   m_pc);
    chk("ifid_inst", if_id_inst_o,           m_inst);
    chk("ifid_pc4",  if_id_pc4_o,            m_pc4);
    chk("ifid_vld",  {31'd0, if_id_valid_o}, {31'd0, m_valid});
    chk("ifid_rs",   {27'd0, if_idrs_o},     {27'd0, m_inst[25:21]});
    chk("ifid_rt",   {27'd0, if_idrt_o},     {27'd0, m_inst[20:16]});
    chk("stall",     {31'd0, fetch_stall_o}, {31'd0, (m_mode == 1) && !imem_ack_i});
  endtask

  task automatic model_step();
    bit go;
    go = pc_write_i && if_id_write_i;
    if (rst_i) begin
      m_mode = 0; m_pc = 0; m_inst = 0; m_pc4 = 0; m_valid = 0; m_buf = 0;
      m_known = 1;
    end else if (m_mode == 0) begin
      if (start_i) m_mode = 1;
    end else if (flush_i) begin
      m_pc = branch_target_i & 32'hFFFF_FFFC;
      m_inst = 0; m_pc4 = 0; m_valid = 0; m_buf = 0;
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (imem_ack_i && go) begin
        m_inst = imem_data_i; m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
      end else if (imem_ack_i) begin
        m_buf = imem_data_i; m_mode = 2;
      end else if (if_id_write_i) begin
        m_inst = 0; m_pc4 = 0; m_valid = 0;
      end
    end else if (go) begin
      m_inst = m_buf; m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
      m_mode = 1;
    end
  endtask

  // One clock: compare outputs at the negedge, advance DUT and model at the posedge.
  task automatic cyc();
    @(negedge clk_i);
    if (m_known) chk_all();
    @(posedge clk_i);
    model_step();
    #1;
  endtask

  task automatic drive(input bit rst, input bit st, input bit pw, input bit iw,
                       input bit fl, input logic [31:0] tgt, input bit ack,
                       input logic [31:0] dat);
    rst_i = rst; start_i = st; pc_write_i = pw; if_id_write_i = iw;
    flush_i = fl; branch_target_i = tgt; imem_ack_i = ack; imem_data_i = dat;
  endtask

  logic [31:0] addr_snap;

  initial begin
    // reset and start, then two back-to-back acks
    drive(1, 0, 1, 1, 0, 0, 0, 0); cyc(); cyc();
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    drive(0, 1, 1, 1, 1, 32'h40, 1, 32'hDEAD_BEEF); cyc();   // flush/ack ignored in IDLE
    chk("start_pc", pc_o, 32'd0);
    chk("start_req", {31'd0, imem_req_o}, 32'd1);
    drive(0, 0, 1, 1, 0, 0, 1, 32'h8C22_0004); cyc();
    chk("f1_inst", if_id_inst_o, 32'h8C22_0004);
    chk("f1_pc4", if_id_pc4_o, 32'h4);
    chk("f1_rs", {27'd0, if_idrs_o}, 32'd1);
    chk("f1_rt", {27'd0, if_idrt_o}, 32'd2);
    drive(0, 0, 1, 1, 0, 0, 1, 32'h0043_0820); cyc();
    chk("f2_inst", if_id_inst_o, 32'h0043_0820);
    chk("f2_pc4", if_id_pc4_o, 32'h8);
    chk("f2_pc", pc_o, 32'h8);

    // ack withheld three cycles: bubbles and a steady address
    addr_snap = imem_addr_o;
    drive(0, 0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("wait_stall", {31'd0, fetch_stall_o}, 32'd1);
      cyc();
      chk("wait_bubble", {31'd0, if_id_valid_o}, 32'd0);
      chk("wait_addr", imem_addr_o, addr_snap);
    end

    // ack during a stall parks the word in HOLD
    drive(0, 0, 0, 0, 0, 0, 1, 32'h1234_5678); cyc();
    chk("hold_req", {31'd0, imem_req_o}, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0); cyc();
    chk("hold_stall", {31'd0, fetch_stall_o}, 32'd0);
    chk("hold_pc", pc_o, 32'h8);
    drive(0, 0, 1, 1, 0, 0, 0, 0); cyc();
    chk("hold_rel_inst", if_id_inst_o, 32'h1234_5678);
    chk("hold_rel_pc", pc_o, 32'hC);

    // flush coincident with ack drops the word
    drive(0, 0, 1, 1, 1, 32'h0000_0103, 1, 32'hAAAA_AAAA); cyc();
    chk("flush_pc", pc_o, 32'h100);
    chk("flush_vld", {31'd0, if_id_valid_o}, 32'd0);

    // PC wrap at the top of the address space
    drive(0, 0, 1, 1, 1, 32'hFFFF_FFFF, 0, 0); cyc();
    chk("wrap_pre", pc_o, 32'hFFFF_FFFC);
    drive(0, 0, 1, 1, 0, 0, 1, 32'h0BAD_F00D); cyc();
    chk("wrap_pc4", if_id_pc4_o, 32'd0);
    chk("wrap_pc", pc_o, 32'd0);

    // reset while requesting, then while in HOLD; late ack in IDLE ignored
    drive(1, 0, 1, 1, 0, 0, 0, 0); cyc();
    chk("rstf_req", {31'd0, imem_req_o}, 32'd0);
    drive(0, 1, 1, 1, 0, 0, 0, 0); cyc();
    drive(0, 0, 0, 1, 0, 0, 1, 32'h5555_5555); cyc();
    drive(1, 0, 1, 1, 1, 32'h80, 1, 32'h6666_6666); cyc();
    chk("rsth_pc", pc_o, 32'd0);
    chk("rsth_inst", if_id_inst_o, 32'd0);
    drive(0, 0, 1, 1, 0, 0, 1, 32'h7777_7777); cyc();
    chk("idle_ack_inst", if_id_inst_o, 32'd0);
    chk("idle_ack_req", {31'd0, imem_req_o}, 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(99) < 2, $urandom_range(99) < 30,
            $urandom_range(99) < 80, $urandom_range(99) < 80,
            $urandom_range(99) < 8, $urandom,
            $urandom_range(99) < 50, $urandom);
      cyc();
    end
    @(negedge clk_i);
    chk_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
